if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the pipeline controller and the IF/ID register.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request and valid-only response bus.
- Buffers the fetched instruction and raises fetched_ok. This signal is the controller's fetched_ok input.
- Obeys the controller's dont_fetch and the redirect (branch/jump/trap/interrupt) PC.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o when no instruction is held.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- if_stage_dont_fetch_i  input  1  from controller; blocks issuing a new request.
- if_stage_advance_i  input  1  pipeline step this cycle (global inst_valid AND NOT id_stall); held instruction is consumed.
- if_stage_redirect_en_i  input  1  single-cycle pulse; the PC is replaced.
- if_stage_redirect_pc_i  input  64  redirect target.
- if_stage_req_valid_o  output  1  memory request valid.
- if_stage_req_ready_i  input  1  memory accepts request.
- if_stage_req_addr_o  output  64  request address, {pc_q[63:3],3'b000}.
- if_stage_resp_valid_i  input  1  response data valid.
- if_stage_resp_data_i  input  64  8-byte-aligned response word.
- if_stage_fetched_ok_o  output  1  an instruction is held; to controller fetched_ok.
- if_stage_pc_o  output  64  PC of held instruction (pc_q).
- if_stage_inst_o  output  32  held instruction, else NOP_INST.

Behaviour:
- Reset values:
  - state=IDLE, pc_q=RESET_PC, kill_q=0, inst_q=NOP_INST.
  - req_valid_o=0, fetched_ok_o=0, req_addr_o={RESET_PC[63:3],3'b0}.
- FSM states: IDLE, REQ, WAIT, HOLD. req_valid_o=1 iff state==REQ. fetched_ok_o=1 iff state==HOLD.
- IDLE:
  - dont_fetch_i=0 and redirect_en_i=0 → REQ next cycle.
  - Otherwise stay in IDLE.
  - redirect_en_i → pc_q<=redirect_pc.
- REQ:
  - req_addr_o stays stable while req_valid_o=1. A request is never withdrawn.
  - req_ready_i=1 → WAIT.
  - redirect_en_i → pc_q<=redirect_pc and kill_q<=1. req_valid_o and req_addr_o keep their current values until accepted.
  - req_addr_o tracks pc_q only while kill_q=0. The address is latched as addr_q at REQ entry.
- WAIT:
  - Only in this state is resp_valid_i sampled. resp_valid_i in any other state is ignored.
  - resp_valid_i=1, kill_q=0, redirect_en_i=0 → inst_q<= addr_q[2] ? data[63:32] : data[31:0]; go to HOLD.
  - resp_valid_i=1 with kill_q=1 or redirect_en_i=1 → discard data, kill_q<=0, go to IDLE.
  - redirect_en_i → pc_q<=redirect_pc. If resp_valid_i is not present the same cycle, kill_q<=1.
- HOLD:
  - redirect_en_i=1, with or without advance → drop held instruction, pc_q<=redirect_pc, go to IDLE. fetched_ok_o is 0 next cycle.
  - else advance_i=1 → pc_q<=pc_q+4 (mod 2^64), go to IDLE.
  - else stay; inst_q and pc_q stable.
- Minimum fetch latency:
  - Request issue to fetched_ok: 1 cycle after the req handshake, plus memory latency.
  - IDLE→REQ costs 1 cycle; per-instruction throughput ≥4 cycles.
- redirect_pc_i[1:0] are forced to 0 on load. Misaligned-target traps are raised elsewhere.
- Multiple redirects while kill_q=1: pc_q takes the latest target. Exactly one response is still discarded.
- dont_fetch_i affects only the IDLE→REQ transition. It never cancels REQ/WAIT/HOLD.
- Async reset mid-transaction: immediate return to reset values. A stale response arriving after reset is ignored because state≠WAIT.
- inst_o=inst_q in HOLD, NOP_INST otherwise.

Test Plan:
- Reset, dont_fetch=0, ready=1, 1-cycle response data 64'h0000_0093_0000_0013 → req_addr=0x8000_0000; fetched_ok=1 with inst=0x0000_0013, pc=0x8000_0000. After advance, next request is addr 0x8000_0000 with pc 0x8000_0004; inst=0x0000_0093 is selected via addr_q[2].
- req_ready held 0 for 3 cycles, redirect to 0x8000_0100 in 2nd cycle → req_addr stays 0x8000_0000 until accepted. Response is discarded and fetched_ok stays 0. Next request uses addr 0x8000_0100.
- In HOLD at pc 0x8000_0008, advance=1 and redirect_en=1 to 0x8000_0203 same cycle → held instruction dropped, pc=0x8000_0200, fetched_ok=0 next cycle.
- dont_fetch=1 for 5 cycles in IDLE → req_valid stays 0. Release → req_valid=1 on the following cycle.
- pc_q=64'hFFFF_FFFF_FFFF_FFFC, advance → pc_q=0, req_addr=0.
- rst asserted during WAIT, resp_valid pulses 2 cycles after release → state stays IDLE→REQ sequence from RESET_PC; stale response ignored and fetched_ok=0.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the program counter and issues one instruction-memory request at a
// time. The request bus uses a valid/ready handshake. The response bus is
// valid-only. A fetched 32-bit instruction is held until the pipeline
// advances or a redirect drops it.
//
// Ports:
//   clk                     clock, all state updates on the rising edge
//   rst                     asynchronous active-high reset
//   if_stage_dont_fetch_i   controller hold-off, blocks only IDLE->REQ
//   if_stage_advance_i      pipeline step, consumes the held instruction
//   if_stage_redirect_en_i  single-cycle pulse that replaces the PC
//   if_stage_redirect_pc_i  redirect target, bits [1:0] forced to zero
//   if_stage_req_valid_o    memory request valid (state REQ)
//   if_stage_req_ready_i    memory accepts the request
//   if_stage_req_addr_o     8-byte-aligned request address
//   if_stage_resp_valid_i   response word valid (sampled only in WAIT)
//   if_stage_resp_data_i    8-byte-aligned response word
//   if_stage_fetched_ok_o   an instruction is held (state HOLD)
//   if_stage_pc_o           PC of the held instruction
//   if_stage_inst_o         held instruction, NOP_INST when none is held
// ----------------------------------------------------------------------------
module if_stage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stage_dont_fetch_i,
   input  logic        if_stage_advance_i,
   input  logic        if_stage_redirect_en_i,
   input  logic [63:0] if_stage_redirect_pc_i,
   output logic        if_stage_req_valid_o,
   input  logic        if_stage_req_ready_i,
   output logic [63:0] if_stage_req_addr_o,
   input  logic        if_stage_resp_valid_i,
   input  logic [63:0] if_stage_resp_data_i,
   output logic        if_stage_fetched_ok_o,
   output logic [63:0] if_stage_pc_o,
   output logic [31:0] if_stage_inst_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state_q;
   logic [63:0] pc_q;
   // Only bits [63:2] of the fetch PC matter: [63:3] form the aligned address,
   // bit 2 selects the instruction half of the returned word.
   logic [63:2] addr_q;
   logic        kill_q;
   logic [31:0] inst_q;
   logic        req_valid_q;
   logic        fetched_ok_q;

   logic [63:0] redir_pc_s;
   logic [31:0] resp_inst_s;

   // Word-align the redirect target; misaligned-target traps are raised elsewhere.
   assign redir_pc_s  = {if_stage_redirect_pc_i[63:2], if_stage_redirect_pc_i[1:0] & 2'b00};

   // Pick the 32-bit half of the response word addressed by the fetch PC.
   assign resp_inst_s = addr_q[2] ? if_stage_resp_data_i[63:32] : if_stage_resp_data_i[31:0];

   // Fetch FSM: PC, kill flag, held instruction and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC[63:2];
         kill_q       <= 1'b0;
         inst_q       <= NOP_INST;
         req_valid_q  <= 1'b0;
         fetched_ok_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (if_stage_redirect_en_i) begin
                  pc_q <= redir_pc_s;
               end else if (!if_stage_dont_fetch_i) begin
                  // Address is frozen here so it cannot move while the request is pending.
                  addr_q      <= pc_q[63:2];
                  req_valid_q <= 1'b1;
                  state_q     <= REQ;
               end
            end

            REQ: begin
               // A request is never withdrawn; a redirect only marks its response stale.
               if (if_stage_redirect_en_i) begin
                  pc_q   <= redir_pc_s;
                  kill_q <= 1'b1;
               end
               if (if_stage_req_ready_i) begin
                  req_valid_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end

            WAIT: begin
               if (if_stage_resp_valid_i) begin
                  if (kill_q || if_stage_redirect_en_i) begin
                     // Exactly one response is discarded per killed request.
                     kill_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     inst_q       <= resp_inst_s;
                     fetched_ok_q <= 1'b1;
                     state_q      <= HOLD;
                  end
                  if (if_stage_redirect_en_i) begin
                     pc_q <= redir_pc_s;
                  end
               end else if (if_stage_redirect_en_i) begin
                  pc_q   <= redir_pc_s;
                  kill_q <= 1'b1;
               end
            end

            HOLD: begin
               // A redirect wins over advance: the held instruction is dropped.
               if (if_stage_redirect_en_i) begin
                  pc_q         <= redir_pc_s;
                  inst_q       <= NOP_INST;
                  fetched_ok_q <= 1'b0;
                  state_q      <= IDLE;
               end else if (if_stage_advance_i) begin
                  pc_q         <= pc_q + 64'd4;
                  inst_q       <= NOP_INST;
                  fetched_ok_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            default: begin
               state_q      <= IDLE;
               kill_q       <= 1'b0;
               inst_q       <= NOP_INST;
               req_valid_q  <= 1'b0;
               fetched_ok_q <= 1'b0;
            end
         endcase
      end
   end

   assign if_stage_req_valid_o  = req_valid_q;
   assign if_stage_req_addr_o   = {addr_q[63:3], 3'b000};
   assign if_stage_fetched_ok_o = fetched_ok_q;
   assign if_stage_pc_o         = pc_q;
   // inst_q is reset to NOP whenever HOLD is left, so it already reads NOP outside HOLD.
   assign if_stage_inst_o       = inst_q;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A table of fetch records drives the main function; hand-written sequences
// cover redirect/kill, dont_fetch hold-off, PC wrap and reset mid-transaction.
// Expected {pc, inst} pairs are queued at the request handshake and popped
// when fetched_ok is raised.
// ----------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        dont_fetch;
   logic        advance;
   logic        redirect_en;
   logic [63:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        fetched_ok;
   logic [63:0] pc_o;
   logic [31:0] inst_o;

   typedef struct {
      logic [63:0] tgt;
      logic [63:0] exp_pc;
      logic [63:0] exp_addr;
      logic [63:0] data;
      logic [31:0] exp_inst;
      int          lat;
      int          rdy_dly;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .if_stage_dont_fetch_i (dont_fetch),
      .if_stage_advance_i    (advance),
      .if_stage_redirect_en_i(redirect_en),
      .if_stage_redirect_pc_i(redirect_pc),
      .if_stage_req_valid_o  (req_valid),
      .if_stage_req_ready_i  (req_ready),
      .if_stage_req_addr_o   (req_addr),
      .if_stage_resp_valid_i (resp_valid),
      .if_stage_resp_data_i  (resp_data),
      .if_stage_fetched_ok_o (fetched_ok),
      .if_stage_pc_o         (pc_o),
      .if_stage_inst_o       (inst_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!req_valid && n < 20) begin
         tick();
         n++;
      end
      chk("req_valid_wait", 64'(req_valid), 64'd1);
   endtask

   // Leaves the DUT in HOLD; dont_fetch is raised after the handshake so a later
   // exit from HOLD parks in IDLE.
   task automatic run_fetch(input vec_t v);
      int   n;
      exp_t e;
      dont_fetch = 1'b0;
      wait_req();
      chk("req_addr", req_addr, v.exp_addr);
      for (int k = 0; k < v.rdy_dly; k++) begin
         tick();
         chk("req_addr_stall", req_addr, v.exp_addr);
      end
      req_ready = 1'b1;
      sb.push_back('{pc: v.exp_pc, inst: v.exp_inst});
      tick();
      req_ready  = 1'b0;
      dont_fetch = 1'b1;
      chk("req_valid_drop", 64'(req_valid), 64'd0);
      for (int k = 0; k < v.lat; k++) begin
         tick();
         chk("wait_no_fetch", 64'(fetched_ok), 64'd0);
      end
      resp_valid = 1'b1;
      resp_data  = v.data;
      tick();
      resp_valid = 1'b0;
      resp_data  = 64'd0;
      n = 0;
      while (!fetched_ok && n < 20) begin
         tick();
         n++;
      end
      chk("fetched_ok_wait", 64'(fetched_ok), 64'd1);
      if (fetched_ok && sb.size() > 0) begin
         e = sb.pop_front();
         chk("held_pc", pc_o, e.pc);
         chk("held_inst", 64'(inst_o), 64'(e.inst));
      end
   endtask

   task automatic redirect_to(input logic [63:0] tgt);
      redirect_en = 1'b1;
      redirect_pc = tgt;
      tick();
      redirect_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{tgt: 64'h0000_0000_8000_0000, exp_pc: 64'h0000_0000_8000_0000,
                  exp_addr: 64'h0000_0000_8000_0000, data: 64'h0000_0093_0000_0013,
                  exp_inst: 32'h0000_0013, lat: 0, rdy_dly: 0};
      vecs[1] = '{tgt: 64'h0000_0000_8000_0004, exp_pc: 64'h0000_0000_8000_0004,
                  exp_addr: 64'h0000_0000_8000_0000, data: 64'h0000_0093_0000_0013,
                  exp_inst: 32'h0000_0093, lat: 0, rdy_dly: 0};
      vecs[2] = '{tgt: 64'h1234_5678_9ABC_DEF7, exp_pc: 64'h1234_5678_9ABC_DEF4,
                  exp_addr: 64'h1234_5678_9ABC_DEF0, data: 64'hCAFE_BABE_DEAD_BEEF,
                  exp_inst: 32'hCAFE_BABE, lat: 2, rdy_dly: 1};
      vecs[3] = '{tgt: 64'h0000_0000_0000_0010, exp_pc: 64'h0000_0000_0000_0010,
                  exp_addr: 64'h0000_0000_0000_0010, data: 64'h1111_2222_3333_4444,
                  exp_inst: 32'h3333_4444, lat: 3, rdy_dly: 2};
      vecs[4] = '{tgt: 64'hFFFF_FFFF_FFFF_FFFE, exp_pc: 64'hFFFF_FFFF_FFFF_FFFC,
                  exp_addr: 64'hFFFF_FFFF_FFFF_FFF8, data: 64'h89AB_CDEF_0123_4567,
                  exp_inst: 32'h89AB_CDEF, lat: 1, rdy_dly: 0};

      rst         = 1'b1;
      dont_fetch  = 1'b1;
      advance     = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 64'd0;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_data   = 64'd0;
      #12;
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_fetched_ok", 64'(fetched_ok), 64'd0);
      chk("rst_req_addr", req_addr, 64'h0000_0000_8000_0000);
      chk("rst_pc", pc_o, RESET_PC);
      chk("rst_inst", 64'(inst_o), 64'(NOP_INST));
      tick();
      rst = 1'b0;

      // Table of fetches; the first starts straight out of reset.
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            dont_fetch = 1'b1;
            advance    = 1'b1;
            tick();
            advance = 1'b0;
            chk("adv_fetched_ok", 64'(fetched_ok), 64'd0);
            chk("adv_pc", pc_o, vecs[i-1].exp_pc + 64'd4);
            chk("adv_inst_nop", 64'(inst_o), 64'(NOP_INST));
            redirect_to(vecs[i].tgt);
            chk("idle_redirect_pc", pc_o, vecs[i].exp_pc);
            chk("idle_redirect_no_req", 64'(req_valid), 64'd0);
         end
         run_fetch(vecs[i]);
      end

      // PC wrap: advance from the top of the address space.
      advance = 1'b1;
      tick();
      advance = 1'b0;
      chk("wrap_pc", pc_o, 64'd0);
      run_fetch('{tgt: 64'd0, exp_pc: 64'd0, exp_addr: 64'd0,
                  data: 64'h0000_0001_0000_0002, exp_inst: 32'h0000_0002, lat: 0, rdy_dly: 0});

      // Redirect while the request is stalled: address stays, response discarded.
      redirect_to(64'h0000_0000_8000_0000);
      chk("hold_redirect_drop", 64'(fetched_ok), 64'd0);
      dont_fetch = 1'b0;
      wait_req();
      chk("kill_addr0", req_addr, 64'h0000_0000_8000_0000);
      tick();
      redirect_to(64'h0000_0000_8000_0100);
      chk("kill_req_held", 64'(req_valid), 64'd1);
      chk("kill_addr_stable", req_addr, 64'h0000_0000_8000_0000);
      chk("kill_pc", pc_o, 64'h0000_0000_8000_0100);
      tick();
      chk("kill_addr_stable2", req_addr, 64'h0000_0000_8000_0000);
      req_ready = 1'b1;
      tick();
      req_ready  = 1'b0;
      dont_fetch = 1'b1;
      resp_valid = 1'b1;
      resp_data  = 64'h0000_0093_0000_0013;
      tick();
      resp_valid = 1'b0;
      chk("kill_discard", 64'(fetched_ok), 64'd0);
      chk("kill_idle", 64'(req_valid), 64'd0);
      tick();
      chk("kill_discard2", 64'(fetched_ok), 64'd0);
      run_fetch('{tgt: 64'd0, exp_pc: 64'h0000_0000_8000_0100, exp_addr: 64'h0000_0000_8000_0100,
                  data: 64'h0000_0AAA_0000_0BBB, exp_inst: 32'h0000_0BBB, lat: 0, rdy_dly: 0});

      // HOLD at 0x8000_0008 with advance and redirect in the same cycle.
      redirect_to(64'h0000_0000_8000_0008);
      run_fetch('{tgt: 64'd0, exp_pc: 64'h0000_0000_8000_0008, exp_addr: 64'h0000_0000_8000_0008,
                  data: 64'h0000_0033_0000_0044, exp_inst: 32'h0000_0044, lat: 1, rdy_dly: 0});
      advance = 1'b1;
      redirect_to(64'h0000_0000_8000_0203);
      advance = 1'b0;
      chk("both_fetched_ok", 64'(fetched_ok), 64'd0);
      chk("both_pc", pc_o, 64'h0000_0000_8000_0200);
      chk("both_inst_nop", 64'(inst_o), 64'(NOP_INST));
      chk("both_idle", 64'(req_valid), 64'd0);

      // dont_fetch held for 5 cycles in IDLE; a stray response must be ignored.
      for (int k = 0; k < 5; k++) begin
         resp_valid = (k == 2);
         tick();
         chk("dont_fetch_no_req", 64'(req_valid), 64'd0);
         chk("dont_fetch_no_hold", 64'(fetched_ok), 64'd0);
      end
      resp_valid = 1'b0;
      dont_fetch = 1'b0;
      tick();
      chk("release_req", 64'(req_valid), 64'd1);
      chk("release_addr", req_addr, 64'h0000_0000_8000_0200);

      // Async reset while waiting for a response; the late response is stale.
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      rst = 1'b1;
      #2;
      chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
      chk("mid_rst_pc", pc_o, RESET_PC);
      chk("mid_rst_addr", req_addr, 64'h0000_0000_8000_0000);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_req", 64'(req_valid), 64'd1);
      chk("post_rst_addr", req_addr, 64'h0000_0000_8000_0000);
      resp_valid = 1'b1;
      resp_data  = 64'h0000_0093_0000_0013;
      tick();
      resp_valid = 1'b0;
      chk("stale_resp_fetched_ok", 64'(fetched_ok), 64'd0);
      chk("stale_resp_req_held", 64'(req_valid), 64'd1);
      tick();
      chk("stale_resp_fetched_ok2", 64'(fetched_ok), 64'd0);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
